// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit (RV32M operation set, any even WIDTH)
// with a start/busy/done handshake and RISC-V divide corner-case results.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       MulDivControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             sign_flag
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_mag_q, a_mag_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;
  logic             neg_q, neg_d;
  logic             special_q, special_d;
  logic [WIDTH-1:0] spec_res_q, spec_res_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;

  // Operand signedness and magnitudes from the live inputs (used only on the start edge)
  always_comb begin
    a_signed = (MulDivControl == 3'b001) || (MulDivControl == 3'b010) ||
               (MulDivControl[2] && !MulDivControl[0]);
    b_signed = (MulDivControl == 3'b001) || (MulDivControl[2] && !MulDivControl[0]);
    a_neg    = a_signed && SrcA[WIDTH-1];
    b_neg    = b_signed && SrcB[WIDTH-1];
    a_mag    = a_neg ? (~SrcA + WIDTH'(1)) : SrcA;
    b_mag    = b_neg ? (~SrcB + WIDTH'(1)) : SrcB;
  end

  // One shift-add / shift-subtract step plus final sign correction of the accumulator
  always_comb begin
    mul_sum  = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
    rem_sh   = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_mag_q};
    prod     = neg_q ? (~acc_q + PW'(1)) : acc_q;
    quo      = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem      = neg_q ? (~acc_q[PW-1:WIDTH] + WIDTH'(1)) : acc_q[PW-1:WIDTH];
  end

  // Next-state and datapath update; special cases load a terminal count and skip the iterations
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    neg_d      = neg_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    acc_d      = acc_q;
    result_d   = result_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d       = MulDivControl;
          a_mag_d    = a_mag;
          b_mag_d    = b_mag;
          neg_d      = (MulDivControl[2] && MulDivControl[1]) ? a_neg : (a_neg ^ b_neg);
          acc_d      = MulDivControl[2] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          cnt_d      = '0;
          special_d  = 1'b0;
          spec_res_d = '0;
          state_d    = CALC;
          if (MulDivControl[2] && (SrcB == '0)) begin
            special_d  = 1'b1;
            spec_res_d = MulDivControl[1] ? SrcA : '1;
          end else if (MulDivControl[2] && !MulDivControl[0] &&
                       (SrcA == MOST_NEG) && (SrcB == '1)) begin
            special_d  = 1'b1;
            spec_res_d = MulDivControl[1] ? '0 : MOST_NEG;
          end
          if (special_d) cnt_d = CNT_W'(WIDTH);
        end
      end
      CALC: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (op_q[2]) begin
            acc_d = {(rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], ~rem_diff[WIDTH]};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (special_q)       result_d = spec_res_q;
        else if (!op_q[2])   result_d = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
        else                 result_d = op_q[1] ? rem : quo;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      neg_q      <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      neg_q      <= neg_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Result    = result_q;
  assign Zero      = (result_q == '0);
  assign sign_flag = result_q[WIDTH-1];

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk, rst, start;
  logic [31:0] src_a, src_b;
  logic [2:0]  ctl;
  logic        busy, done, zero, sign_flag;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .SrcA(src_a), .SrcB(src_b),
    .MulDivControl(ctl), .busy(busy), .done(done), .Result(result),
    .Zero(zero), .sign_flag(sign_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation for a single start edge, then scramble the inputs
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ctl = op; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ctl = REM; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678;
  endtask

  // Cycles from the last sampled edge until done is seen; -1 on timeout
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (result !== 32'h0)     begin n_fail++; $display("FAIL reset_result got %h exp 0", result); end
    n_checks++; if (zero !== 1'b1)        begin n_fail++; $display("FAIL reset_zero got %b exp 1", zero); end
    n_checks++; if (sign_flag !== 1'b0)   begin n_fail++; $display("FAIL reset_sign got %b exp 0", sign_flag); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int lat;
    issue(MUL, 32'd5, 32'd15);
    wait_done(lat);
    n_checks++; if (lat != 34)            begin n_fail++; $display("FAIL mul_latency got %0d exp 34", lat); end
    n_checks++; if (result !== 32'd75)    begin n_fail++; $display("FAIL mul_result got %h exp %h", result, 32'd75); end
    n_checks++; if (zero !== 1'b0)        begin n_fail++; $display("FAIL mul_zero got %b exp 0", zero); end
    n_checks++; if (sign_flag !== 1'b0)   begin n_fail++; $display("FAIL mul_sign got %b exp 0", sign_flag); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL mul_done_pulse got %b exp 0", done); end
    n_checks++; if (result !== 32'd75)    begin n_fail++; $display("FAIL mul_hold got %h exp %h", result, 32'd75); end
  endtask

  task automatic test_reset_midop();
    int seen;
    issue(DIVU, 32'd1000, 32'd3);
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL midop_busy got %b exp 1", busy); end
    #3 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL midop_rst_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL midop_rst_done got %b exp 0", done); end
    n_checks++; if (result !== 32'h0)     begin n_fail++; $display("FAIL midop_rst_result got %h exp 0", result); end
    n_checks++; if (zero !== 1'b1)        begin n_fail++; $display("FAIL midop_rst_zero got %b exp 1", zero); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (50) begin @(posedge clk); #1; if (done) seen++; end
    n_checks++; if (seen != 0)            begin n_fail++; $display("FAIL midop_no_done got %0d pulses exp 0", seen); end
  endtask

  task automatic test_mul_high();
    logic [2:0]  op  [5];
    logic [31:0] a   [5];
    logic [31:0] b   [5];
    logic [31:0] exp [5];
    int lat;
    op  = '{MULH, MULHU, MULHSU, MULH, MUL};
    a   = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    b   = '{32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
    exp = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFF1};
    for (int i = 0; i < 5; i++) begin
      issue(op[i], a[i], b[i]);
      wait_done(lat);
      n_checks++; if (lat != 34)         begin n_fail++; $display("FAIL mulh_latency[%0d] got %0d exp 34", i, lat); end
      n_checks++; if (result !== exp[i]) begin n_fail++; $display("FAIL mulh_result[%0d] got %h exp %h", i, result, exp[i]); end
      n_checks++; if (sign_flag !== exp[i][31]) begin n_fail++; $display("FAIL mulh_sign[%0d] got %b exp %b", i, sign_flag, exp[i][31]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  op  [7];
    logic [31:0] a   [7];
    logic [31:0] b   [7];
    logic [31:0] exp [7];
    int lat;
    op  = '{DIV, REM, REM, DIVU, REMU, DIV, REM};
    a   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd6, 32'd100, 32'd100, 32'd7, 32'd7};
    b   = '{32'd2, 32'd2, 32'd3, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    exp = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd0, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
    for (int i = 0; i < 7; i++) begin
      issue(op[i], a[i], b[i]);
      wait_done(lat);
      n_checks++; if (lat != 34)         begin n_fail++; $display("FAIL div_latency[%0d] got %0d exp 34", i, lat); end
      n_checks++; if (result !== exp[i]) begin n_fail++; $display("FAIL div_result[%0d] got %h exp %h", i, result, exp[i]); end
      n_checks++; if (zero !== (exp[i] == 32'h0)) begin n_fail++; $display("FAIL div_zero[%0d] got %b", i, zero); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  op  [6];
    logic [31:0] a   [6];
    logic [31:0] b   [6];
    logic [31:0] exp [6];
    int lat;
    op  = '{DIVU, REMU, DIV, REM, DIV, REM};
    a   = '{32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
    b   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    exp = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    for (int i = 0; i < 6; i++) begin
      issue(op[i], a[i], b[i]);
      wait_done(lat);
      n_checks++; if (lat != 2)          begin n_fail++; $display("FAIL special_latency[%0d] got %0d exp 2", i, lat); end
      n_checks++; if (result !== exp[i]) begin n_fail++; $display("FAIL special_result[%0d] got %h exp %h", i, result, exp[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    issue(DIVU, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL busy_start_busy got %b exp 1", busy); end
    start = 1'b1; ctl = MUL; src_a = 32'd3; src_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    n_checks++; if (lat != 24)            begin n_fail++; $display("FAIL busy_start_latency got %0d exp 24", lat); end
    n_checks++; if (result !== 32'd14)    begin n_fail++; $display("FAIL busy_start_result got %h exp %h", result, 32'd14); end
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL busy_start_idle got %b exp 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(MUL, 32'd6, 32'd7);
    wait_done(lat);
    n_checks++; if (result !== 32'd42)    begin n_fail++; $display("FAIL b2b_first got %h exp %h", result, 32'd42); end
    start = 1'b1; ctl = DIVU; src_a = 32'd99; src_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; src_a = 32'd1; src_b = 32'd1;
    n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL b2b_done_fall got %b exp 0", done); end
    n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL b2b_busy got %b exp 1", busy); end
    wait_done(lat);
    n_checks++; if (lat != 34)            begin n_fail++; $display("FAIL b2b_latency got %0d exp 34", lat); end
    n_checks++; if (result !== 32'd11)    begin n_fail++; $display("FAIL b2b_second got %h exp %h", result, 32'd11); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ctl = MUL; src_a = '0; src_b = '0;
    test_reset();
    test_mul();
    test_reset_midop();
    test_mul_high();
    test_div();
    test_special();
    test_start_while_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
